ps2_player_keymap: RTL and testbench



---
 rtl/ps2_keymap_pkg.sv | 40 ++++
 rtl/ps2_seq_parser.sv | 93 +++++++++
 rtl/ps2_player_keymap.sv | 90 +++++++++
 tb/tb_ps2_player_keymap.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_keymap_pkg.sv
// Shared constants and types for the PS/2 player keymap: scan-code bytes,
// the prefix FSM states and key-slot indices.
package ps2_keymap_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  localparam int unsigned KEYS_PER_PLAYER = 5;
  localparam int unsigned K_LEFT          = 0;
  localparam int unsigned K_RIGHT         = 1;
  localparam int unsigned K_UP            = 2;
  localparam int unsigned K_DOWN          = 3;
  localparam int unsigned K_ACTION        = 4;

  // One keymap entry is {ext, code[7:0]}.
  localparam int unsigned KEY_ENTRY_W = 9;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } seq_state_e;

  // Bytes that mean the keyboard reset or overran: drop every held key.
  function automatic logic is_clear_byte(input logic [7:0] b);
    return (b == SC_ERR0) || (b == SC_ERR1) || (b == SC_BAT);
  endfunction

  // Host-protocol replies that must not disturb a sequence in flight.
  function automatic logic is_ignored_byte(input logic [7:0] b);
    return (b == SC_ACK) || (b == SC_RESEND);
  endfunction

endpackage

// File: rtl/ps2_seq_parser.sv
// Scan-code set 2 prefix parser: folds E0/F0 prefixes into one make/break
// event per completed sequence and drops partial sequences that stall.
module ps2_seq_parser
  import ps2_keymap_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] scan_code_i,
  input  logic       scan_valid_i,
  output logic       ev_valid_o,
  output logic       ev_ext_o,
  output logic       ev_brk_o,
  output logic [7:0] ev_code_o,
  output logic       clr_all_o,
  output logic       seq_err_o
);

  localparam int unsigned    CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ext, in_brk;
  logic             byte_take;

  assign byte_take = scan_valid_i && !is_ignored_byte(scan_code_i);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the branches below can leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = '0;
    in_ext     = 1'b0;
    in_brk     = 1'b0;
    ev_valid_o = 1'b0;
    ev_code_o  = scan_code_i;
    clr_all_o  = 1'b0;
    seq_err_o  = 1'b0;

    unique case (state_q)
      EXT:     in_ext = 1'b1;
      BRK:     in_brk = 1'b1;
      EXT_BRK: begin
        in_ext = 1'b1;
        in_brk = 1'b1;
      end
      default: ;
    endcase

    if (byte_take) begin
      if (is_clear_byte(scan_code_i)) begin
        clr_all_o = 1'b1;
        state_d   = IDLE;
      end else if (scan_code_i == SC_EXT) begin
        // E0 always restarts an extended sequence, dropping a pending break.
        state_d = EXT;
      end else if (scan_code_i == SC_BRK) begin
        state_d = in_ext ? EXT_BRK : BRK;
      end else begin
        ev_valid_o = 1'b1;
        state_d    = IDLE;
      end
    end else if (state_q != IDLE) begin
      if (cnt_q == TIMEOUT_LAST) begin
        state_d   = IDLE;
        seq_err_o = 1'b1;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  assign ev_ext_o = in_ext;
  assign ev_brk_o = in_brk;

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of process evaluation order.
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_player_keymap.sv
// Multi-player PS/2 key decoder: tracks held keys from parsed scan events,
// emits per-key press pulses and drives control lines with per-player polarity.
module ps2_player_keymap
  import ps2_keymap_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter logic [NUM_PLAYERS*KEYS_PER_PLAYER*KEY_ENTRY_W-1:0] KEY_MAP = {
    9'h114, 9'h172, 9'h175, 9'h174, 9'h16B,
    9'h029, 9'h01B, 9'h01D, 9'h023, 9'h01C
  },
  parameter logic [NUM_PLAYERS-1:0] ACTIVE_LOW     = 2'b01,
  parameter int unsigned            TIMEOUT_CYCLES = 50000
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic [7:0]                             SCAN_CODE,
  input  logic                                   SCAN_VALID,
  output logic [NUM_PLAYERS*KEYS_PER_PLAYER-1:0] DIR_OUT,
  output logic [NUM_PLAYERS*KEYS_PER_PLAYER-1:0] PRESS_PULSE,
  output logic                                   SEQ_ERR
);

  localparam int unsigned N_KEYS = NUM_PLAYERS * KEYS_PER_PLAYER;

  logic             ev_valid, ev_ext, ev_brk, clr_all, seq_err;
  logic [7:0]       ev_code;
  logic [N_KEYS-1:0] match;
  logic [N_KEYS-1:0] held_q, held_d;
  logic [N_KEYS-1:0] pulse_q, pulse_d;
  logic [N_KEYS-1:0] pol_mask;
  logic             seq_err_q;

  ps2_seq_parser #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_parser (
    .clk_i        (CLK),
    .rst_i        (RST),
    .scan_code_i  (SCAN_CODE),
    .scan_valid_i (SCAN_VALID),
    .ev_valid_o   (ev_valid),
    .ev_ext_o     (ev_ext),
    .ev_brk_o     (ev_brk),
    .ev_code_o    (ev_code),
    .clr_all_o    (clr_all),
    .seq_err_o    (seq_err)
  );

  // Every slot compares in parallel, so one code may drive several keys.
  always_comb begin
    match = '0;
    for (int i = 0; i < int'(N_KEYS); i++) begin
      match[i] = ev_valid &&
                 (KEY_MAP[i*KEY_ENTRY_W +: KEY_ENTRY_W] == {ev_ext, ev_code});
    end
  end

  always_comb begin
    held_d = held_q;
    if (clr_all) begin
      held_d = '0;
    end else if (ev_brk) begin
      held_d = held_q & ~match;
    end else begin
      held_d = held_q | match;
    end
    // Only released->held edges pulse; typematic repeats and clears do not.
    pulse_d = held_d & ~held_q;
  end

  for (genvar p = 0; p < int'(NUM_PLAYERS); p++) begin : g_pol
    assign pol_mask[p*KEYS_PER_PLAYER +: KEYS_PER_PLAYER] = {KEYS_PER_PLAYER{ACTIVE_LOW[p]}};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      held_q    <= '0;
      pulse_q   <= '0;
      seq_err_q <= 1'b0;
    end else begin
      held_q    <= held_d;
      pulse_q   <= pulse_d;
      seq_err_q <= seq_err;
    end
  end

  assign DIR_OUT     = held_q ^ pol_mask;
  assign PRESS_PULSE = pulse_q;
  assign SEQ_ERR     = seq_err_q;

endmodule

// File: tb/tb_ps2_player_keymap.sv
// Directed bench for ps2_player_keymap with a prefix-flag reference model
// compared every cycle, plus literal expectations at key points.
module tb_ps2_player_keymap;

  localparam int unsigned TMO = 8;

  logic       clk = 1'b0;
  logic       RST;
  logic [7:0] SCAN_CODE;
  logic       SCAN_VALID;
  logic [9:0] DIR_OUT;
  logic [9:0] PRESS_PULSE;
  logic       SEQ_ERR;

  int n_checks = 0;
  int n_pass   = 0;

  ps2_player_keymap #(
    .NUM_PLAYERS    (2),
    .ACTIVE_LOW     (2'b01),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK         (clk),
    .RST         (RST),
    .SCAN_CODE   (SCAN_CODE),
    .SCAN_VALID  (SCAN_VALID),
    .DIR_OUT     (DIR_OUT),
    .PRESS_PULSE (PRESS_PULSE),
    .SEQ_ERR     (SEQ_ERR)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Default key table: p0 A D W S Space, p1 E0-prefixed arrows and right Ctrl.
  localparam logic [8:0] KEYS [10] = '{
    9'h01C, 9'h023, 9'h01D, 9'h01B, 9'h029,
    9'h16B, 9'h174, 9'h175, 9'h172, 9'h114
  };
  localparam logic [9:0] RELEASED = 10'h01F;

  logic [9:0] m_held  = '0;
  logic [9:0] exp_dir = RELEASED;
  logic [9:0] exp_pulse = '0;
  logic       exp_err = 1'b0;
  bit         p_ext, p_brk, started;
  int         idle_cnt;

  // Model: a pending sequence is just two flags plus an idle-cycle count.
  task automatic model_step();
    logic [9:0] prev;
    prev    = m_held;
    exp_err = 1'b0;
    if (RST) begin
      m_held = '0; p_ext = 0; p_brk = 0; idle_cnt = 0;
    end else if (SCAN_VALID && SCAN_CODE != 8'hFA && SCAN_CODE != 8'hFE) begin
      idle_cnt = 0;
      if (SCAN_CODE == 8'h00 || SCAN_CODE == 8'hFF || SCAN_CODE == 8'hAA) begin
        m_held = '0; p_ext = 0; p_brk = 0;
      end else if (SCAN_CODE == 8'hE0) begin
        p_ext = 1; p_brk = 0;
      end else if (SCAN_CODE == 8'hF0) begin
        p_brk = 1;
      end else begin
        for (int i = 0; i < 10; i++)
          if (KEYS[i] == {p_ext, SCAN_CODE}) m_held[i] = !p_brk;
        p_ext = 0; p_brk = 0;
      end
    end else if (p_ext || p_brk) begin
      idle_cnt++;
      if (idle_cnt == TMO) begin
        exp_err = 1'b1; p_ext = 0; p_brk = 0; idle_cnt = 0;
      end
    end
    exp_pulse = (RST) ? '0 : (m_held & ~prev);
    exp_dir   = m_held ^ RELEASED;
    started   = 1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      check("model_dir",   DIR_OUT,     exp_dir);
      check("model_pulse", PRESS_PULSE, exp_pulse);
      check("model_err",   SEQ_ERR,     exp_err);
    end
  end

  task automatic send(input logic [7:0] b);
    SCAN_CODE  = b;
    SCAN_VALID = 1'b1;
    @(posedge clk); #2;
    SCAN_VALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int err_at, err_cnt;

  initial begin
    RST = 1'b1; SCAN_CODE = 8'h00; SCAN_VALID = 1'b0;
    repeat (3) @(posedge clk);
    #2 RST = 1'b0;
    @(negedge clk);
    check("reset_dir",   DIR_OUT,     10'h01F);
    check("reset_pulse", PRESS_PULSE, 10'h000);
    check("reset_err",   SEQ_ERR,     1'b0);

    // W press / release on active-low player 0
    send(8'h1D);
    @(negedge clk);
    check("w_make_dir",   DIR_OUT,     10'h01B);
    check("w_make_pulse", PRESS_PULSE, 10'h004);
    @(negedge clk);
    check("w_pulse_gone", PRESS_PULSE, 10'h000);
    send(8'hF0); send(8'h1D);
    @(negedge clk);
    check("w_break_dir", DIR_OUT, 10'h01F);

    // Extended up arrow on active-high player 1 with typematic repeats
    send(8'hE0); send(8'h75);
    @(negedge clk);
    check("up_make_dir",   DIR_OUT,     10'h09F);
    check("up_make_pulse", PRESS_PULSE, 10'h080);
    send(8'hE0); send(8'h75);
    @(negedge clk);
    check("up_rep1_pulse", PRESS_PULSE, 10'h000);
    send(8'hE0); send(8'h75);
    @(negedge clk);
    check("up_rep2_pulse", PRESS_PULSE, 10'h000);
    send(8'hE0); send(8'hF0); send(8'h75);
    @(negedge clk);
    check("up_break_dir", DIR_OUT, 10'h01F);

    // ext flag is part of the match
    send(8'h75);
    @(negedge clk);
    check("bare75_dir", DIR_OUT, 10'h01F);
    send(8'h6B);
    @(negedge clk);
    check("bare6b_dir", DIR_OUT, 10'h01F);

    // Prefix timeout
    send(8'hE0);
    err_at = 0; err_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (SEQ_ERR) begin
        err_cnt++;
        if (err_at == 0) err_at = i;
      end
    end
    check("timeout_cycle", err_at, 9);
    check("timeout_once",  err_cnt, 1);
    send(8'h1C);
    @(negedge clk);
    check("after_tmo_dir",   DIR_OUT,     10'h01E);
    check("after_tmo_pulse", PRESS_PULSE, 10'h001);

    // Hold several keys, then BAT clears everything without pulses
    send(8'h23); send(8'hE0); send(8'h14);
    @(negedge clk);
    check("multi_hold_dir", DIR_OUT, 10'h21C);
    send(8'hAA);
    @(negedge clk);
    check("bat_clear_dir",   DIR_OUT,     10'h01F);
    check("bat_clear_pulse", PRESS_PULSE, 10'h000);

    // Byte arriving on the timeout cycle cancels the timeout
    send(8'hE0);
    repeat (TMO - 1) @(posedge clk);
    #2;
    send(8'h75);
    @(negedge clk);
    check("tmo_cancel_dir", DIR_OUT, 10'h09F);
    check("tmo_cancel_err", SEQ_ERR, 1'b0);

    // ACK inside a break sequence is transparent
    send(8'hE0); send(8'hF0); send(8'hFA); send(8'h75);
    @(negedge clk);
    check("ack_ignored_dir", DIR_OUT, 10'h01F);

    // F0 then E0 restarts as an extended make
    send(8'hF0); send(8'hE0); send(8'h75);
    @(negedge clk);
    check("restart_dir",   DIR_OUT,     10'h09F);
    check("restart_pulse", PRESS_PULSE, 10'h080);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE1);
    @(negedge clk);
    check("e1_dir", DIR_OUT, 10'h01F);

    // Reset wins over a simultaneous valid byte
    send(8'h23);
    @(negedge clk);
    check("pre_rst_dir", DIR_OUT, 10'h01D);
    SCAN_CODE = 8'h29; SCAN_VALID = 1'b1; RST = 1'b1;
    @(posedge clk); #2;
    SCAN_VALID = 1'b0; RST = 1'b0;
    @(negedge clk);
    check("rst_win_dir",   DIR_OUT,     10'h01F);
    check("rst_win_pulse", PRESS_PULSE, 10'h000);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
